if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//   Parametrised instruction-fetch stage with an in-order prefetch queue and a PC redirect port.
//   Drives the instruction-memory port and keeps fetching ahead while the decode stage stalls.
//   Buffers up to DEPTH {PC, instruction} pairs and presents them with a valid/stall handshake.
//   Flushes the queue and restarts fetch at a new PC when a branch/jump redirect arrives.
// PARAMETERS
//   WIDTH     64  PC / address width in bits
//   INST_W    32  instruction word width in bits
//   DEPTH     4   queue entries; power of 2, >= 2
//   RESET_PC  0   first fetch address after reset; bits [1:0] must be 0
// PORTS
//   p_clk                 in   1       single clock; all state updates on posedge
//   p_reset               in   1       one clock; reset is asynchronous and active-high
//   p_INST_MemDataIn      in   INST_W  instruction for the address presented this cycle
//   p_INST_MemWait        in   1       1 = memory not ready; request must be held
//   p_IF_INST_MemAddress  out  WIDTH   fetch address (the fetch PC)
//   p_IF_INST_MemRead     out  1       fetch request
//   p_redirect_valid      in   1       1 = flush the queue, restart fetch at p_redirect_pc
//   p_redirect_pc         in   WIDTH   redirect target; bits [1:0] are ignored (forced to 0)
//   p_ID_stall            in   1       1 = decode cannot accept the head entry this cycle
//   p_IF_valid            out  1       the head entry is valid
//   p_IF_Instruction      out  INST_W  head instruction
//   p_PC_Counter          out  WIDTH   PC of the head instruction
// BEHAVIOUR
//   Reset (asynchronous, takes effect immediately):
//   - fetch PC = RESET_PC; queue empty (count = 0); MemRead = 0; IF_valid = 0.
//   - Instruction = 0; PC_Counter = 0.
//   Fetch request:
//   - MemRead = ~p_reset & (count != DEPTH) & ~p_redirect_valid.
//   - MemAddress always equals the fetch PC.
//   Fetch accept:
//   - Occurs on a cycle with MemRead=1 and MemWait=0.
//   - MemDataIn is sampled that same cycle and pushed with the fetch PC.
//   - Fetch PC += 4, modulo 2^WIDTH (wraps silently).
//   - While MemWait=1, the address is held and nothing is pushed.
//   Pop:
//   - Occurs when IF_valid=1 and p_ID_stall=0; the head advances on the next edge.
//   - Latency: accepted fetch -> IF_valid = 1 cycle (the entry is registered).
//   - Push and pop in the same cycle: count unchanged.
//   - A full queue blocks fetch even if a pop occurs that cycle; fetch resumes the next cycle.
//   - Empty queue: IF_valid=0, Instruction and PC_Counter driven to 0.
//   - p_ID_stall is ignored while the queue is empty.
//   Redirect (p_redirect_valid=1):
//   - Next edge: queue emptied, count=0, fetch PC = {p_redirect_pc[WIDTH-1:2],2'b00}.
//   - Any pop or push in that cycle is discarded.
//   - The first redirected instruction has IF_valid no earlier than 2 cycles after the redirect.
//   - Redirect during MemWait: the pending request is abandoned and the new address is driven.
//   - Back-to-back redirects: the last one wins.
//   Reset asserted mid-operation: all state returns to reset values at once; queue contents are lost.
//   Pointers: log2(DEPTH) bits, wrapping naturally; count: log2(DEPTH)+1 bits, range 0..DEPTH.
// CONFIGURATION
//   IF_FETCH_STATS_EN defined:
//   - Adds output p_fetch_cnt [31:0]: accepted fetches.
//   - Adds output p_wait_cnt [31:0]: cycles with MemRead=1 and MemWait=1.
//   - Both counters saturate at 32'hFFFFFFFF, reset to 0, and are not cleared by redirect.
//   IF_FETCH_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1 Reset, RESET_PC=0, no wait/stall -> addresses 0,4,8,..; IF_valid high from cycle 2; PC_Counter 0,4,8 in order.
//   2 p_ID_stall=1 held -> exactly DEPTH(4) pushes, then MemRead=0, MemAddress=0x10; release -> entries 0,4,8,C then 0x10.
//   3 MemWait=1 for 3 cycles at address 0x8 -> address held at 0x8, no push; after release 0x8 is enqueued once.
//   4 Redirect to 0x1003 with 3 entries queued -> IF_valid=0 next cycle, MemAddress=0x1000; next valid PC=0x1000.
//   5 Fetch PC=2^WIDTH-4 -> next address 0; wrapped entries are delivered in order.
//   6 Reset pulse mid-stream (queue full, MemWait=1) -> all outputs return to reset values immediately; fetch restarts at RESET_PC.
//     With IF_FETCH_STATS_EN: the counters read 0 after reset.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with an in-order {PC, instruction} prefetch queue and a redirect port.
// Optional statistics counters (p_fetch_cnt, p_wait_cnt) are built when IF_FETCH_STATS_EN is defined.
module if_fetch_queue #(
    parameter int                WIDTH    = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                 p_clk,
    input  logic                 p_reset,
    input  logic [INST_W-1:0]    p_INST_MemDataIn,
    input  logic                 p_INST_MemWait,
    output logic [WIDTH-1:0]     p_IF_INST_MemAddress,
    output logic                 p_IF_INST_MemRead,
    input  logic                 p_redirect_valid,
    input  logic [WIDTH-1:0]     p_redirect_pc,
    input  logic                 p_ID_stall,
    output logic                 p_IF_valid,
    output logic [INST_W-1:0]    p_IF_Instruction,
    output logic [WIDTH-1:0]     p_PC_Counter
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0]          p_fetch_cnt,
    output logic [31:0]          p_wait_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic              push, pop, not_empty;
    logic              unused_rpc_bits;

    assign unused_rpc_bits = ^p_redirect_pc[1:0];

    assign not_empty            = (count_q != '0);
    assign p_IF_INST_MemRead    = ~p_reset & (count_q != FULL) & ~p_redirect_valid;
    assign p_IF_INST_MemAddress = fetch_pc_q;
    assign push                 = p_IF_INST_MemRead & ~p_INST_MemWait;
    // A redirect discards any pop that would otherwise happen this cycle.
    assign pop                  = not_empty & ~p_ID_stall & ~p_redirect_valid;

    assign p_IF_valid       = not_empty;
    assign p_IF_Instruction = not_empty ? inst_mem_q[head_q] : '0;
    assign p_PC_Counter     = not_empty ? pc_mem_q[head_q]   : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (p_redirect_valid) begin
            fetch_pc_d = {p_redirect_pc[WIDTH-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + WIDTH'(4);
                tail_d     = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge p_clk) begin
        if (push) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            inst_mem_q[tail_q] <= p_INST_MemDataIn;
        end
    end

`ifdef IF_FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, wait_cnt_q;

    always_ff @(posedge p_clk or posedge p_reset) begin
        if (p_reset) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (push && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (p_IF_INST_MemRead && p_INST_MemWait && (wait_cnt_q != 32'hFFFF_FFFF)) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign p_fetch_cnt = fetch_cnt_q;
    assign p_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue against a queue-based reference model.
// Memory returns a hash of the address so each queued entry's instruction is checkable.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        p_clk = 1'b0;
    logic        p_reset;
    logic [31:0] p_INST_MemDataIn;
    logic        p_INST_MemWait;
    logic [63:0] p_IF_INST_MemAddress;
    logic        p_IF_INST_MemRead;
    logic        p_redirect_valid;
    logic [63:0] p_redirect_pc;
    logic        p_ID_stall;
    logic        p_IF_valid;
    logic [31:0] p_IF_Instruction;
    logic [63:0] p_PC_Counter;
`ifdef IF_FETCH_STATS_EN
    logic [31:0] p_fetch_cnt, p_wait_cnt;
    int unsigned m_fc, m_wc, exp_fc, exp_wc;
`endif

    if_fetch_queue #(.WIDTH(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .p_clk(p_clk),
        .p_reset(p_reset),
        .p_INST_MemDataIn(p_INST_MemDataIn),
        .p_INST_MemWait(p_INST_MemWait),
        .p_IF_INST_MemAddress(p_IF_INST_MemAddress),
        .p_IF_INST_MemRead(p_IF_INST_MemRead),
        .p_redirect_valid(p_redirect_valid),
        .p_redirect_pc(p_redirect_pc),
        .p_ID_stall(p_ID_stall),
        .p_IF_valid(p_IF_valid),
        .p_IF_Instruction(p_IF_Instruction),
        .p_PC_Counter(p_PC_Counter)
`ifdef IF_FETCH_STATS_EN
        ,
        .p_fetch_cnt(p_fetch_cnt),
        .p_wait_cnt(p_wait_cnt)
`endif
    );

    always #5 p_clk = ~p_clk;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    assign p_INST_MemDataIn = mem_fn(p_IF_INST_MemAddress);

    logic [63:0]  q_pc[$];
    logic [31:0]  q_inst[$];
    logic [63:0]  m_pc;
    logic [161:0] exp_obs, obs;
    int           total = 0;
    int           bad   = 0;

    assign obs = {p_IF_valid, p_IF_INST_MemRead, p_IF_INST_MemAddress, p_PC_Counter, p_IF_Instruction};

    // Applies one cycle of inputs, computes the expected pre-edge outputs, then advances the model.
    task automatic drive(input logic r, input logic w, input logic s, input logic v, input logic [63:0] t);
        logic e_read, e_valid;
        @(negedge p_clk);
        p_reset = r; p_INST_MemWait = w; p_ID_stall = s; p_redirect_valid = v; p_redirect_pc = t;
        #1;
        if (r) begin
            q_pc.delete(); q_inst.delete(); m_pc = RESET_PC;
`ifdef IF_FETCH_STATS_EN
            m_fc = 0; m_wc = 0;
`endif
        end
        e_read  = !r && (q_pc.size() != DEPTH) && !v;
        e_valid = (q_pc.size() != 0);
        exp_obs = {e_valid, e_read, m_pc, e_valid ? q_pc[0] : 64'd0, e_valid ? q_inst[0] : 32'd0};
`ifdef IF_FETCH_STATS_EN
        exp_fc = m_fc; exp_wc = m_wc;
`endif
        if (!r) begin
            if (v) begin
                q_pc.delete(); q_inst.delete();
                m_pc = {t[63:2], 2'b00};
            end else begin
                if (e_valid && !s) begin
                    void'(q_pc.pop_front()); void'(q_inst.pop_front());
                end
                if (e_read && !w) begin
                    q_pc.push_back(m_pc); q_inst.push_back(mem_fn(m_pc));
                    m_pc = m_pc + 64'd4;
`ifdef IF_FETCH_STATS_EN
                    m_fc++;
`endif
                end
`ifdef IF_FETCH_STATS_EN
                if (e_read && w) m_wc++;
`endif
            end
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 64'd0);
        total++;
        if (obs !== exp_obs) begin
            bad++; $display("FAIL reset got=%h exp=%h", obs, exp_obs);
        end
        drive(1, 1, 1, 0, 64'd0);
        total++;
        if (obs !== exp_obs) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_obs);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
    endtask

    task automatic test_stall_full();
        drive(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL stall_full cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
        total++;
        if (p_IF_INST_MemRead !== 1'b0 || p_IF_INST_MemAddress !== 64'h10) begin
            bad++; $display("FAIL full_block read=%b addr=%h exp read=0 addr=10", p_IF_INST_MemRead, p_IF_INST_MemAddress);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL stall_release cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
    endtask

    task automatic test_wait();
        drive(1, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 64'd0);
            total++;
            if (obs !== exp_obs || p_IF_INST_MemAddress !== 64'h8) begin
                bad++; $display("FAIL wait_hold cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL wait_release cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
    endtask

    task automatic test_redirect();
        drive(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 64'd0);
        drive(0, 0, 0, 1, 64'h1003);
        total++;
        if (obs !== exp_obs) begin
            bad++; $display("FAIL redirect_cyc got=%h exp=%h", obs, exp_obs);
        end
        drive(0, 0, 0, 0, 64'd0);
        total++;
        if (p_IF_valid !== 1'b0 || p_IF_INST_MemAddress !== 64'h1000 || obs !== exp_obs) begin
            bad++; $display("FAIL redirect_flush valid=%b addr=%h exp valid=0 addr=1000", p_IF_valid, p_IF_INST_MemAddress);
        end
        drive(0, 0, 0, 0, 64'd0);
        total++;
        if (p_IF_valid !== 1'b1 || p_PC_Counter !== 64'h1000 || obs !== exp_obs) begin
            bad++; $display("FAIL redirect_first valid=%b pc=%h exp valid=1 pc=1000", p_IF_valid, p_PC_Counter);
        end
        drive(0, 1, 0, 1, 64'h2000);
        drive(0, 1, 0, 1, 64'h3007);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL redirect_b2b cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, i[0], 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
    endtask

    task automatic test_random();
        logic w, s, v;
        logic [63:0] t;
        drive(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 2) == 0);
            v = ($urandom_range(0, 24) == 0);
            t = {$urandom, $urandom};
            drive(0, w, s, v, t);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
`ifdef IF_FETCH_STATS_EN
            total++;
            if (p_fetch_cnt !== exp_fc || p_wait_cnt !== exp_wc) begin
                bad++; $display("FAIL random_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", i, p_fetch_cnt, p_wait_cnt, exp_fc, exp_wc);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 64'd0);
        drive(0, 1, 1, 0, 64'd0);
        drive(1, 1, 1, 0, 64'd0);
        total++;
        if (obs !== exp_obs || p_IF_valid !== 1'b0 || p_IF_INST_MemAddress !== RESET_PC) begin
            bad++; $display("FAIL reset_mid got=%h exp=%h", obs, exp_obs);
        end
`ifdef IF_FETCH_STATS_EN
        total++;
        if (p_fetch_cnt !== 32'd0 || p_wait_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_mid_stats got=%0d/%0d exp=0/0", p_fetch_cnt, p_wait_cnt);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 64'd0);
            total++;
            if (obs !== exp_obs) begin
                bad++; $display("FAIL reset_restart cyc=%0d got=%h exp=%h", i, obs, exp_obs);
            end
        end
    endtask

    initial begin
        p_reset = 1'b1; p_INST_MemWait = 1'b0; p_ID_stall = 1'b0;
        p_redirect_valid = 1'b0; p_redirect_pc = 64'd0;
        m_pc = RESET_PC;
`ifdef IF_FETCH_STATS_EN
        m_fc = 0; m_wc = 0;
`endif
        test_reset();
        test_stream();
        test_stall_full();
        test_wait();
        test_redirect();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
